// File: rtl/fifo_pkg.sv
// Shared definitions for the TDP18K FIFO-mode wrappers and their stream adapters.
package fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] level_t;

  typedef enum logic {
    MODE_18 = 1'b0,
    MODE_9  = 1'b1
  } width_mode_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered output buffer (head + skid) with push, pop, clear and level.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output level_t                o_level,
  output logic                  o_drop
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  level_t                r_level;

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the data registers are reset too because DATA_o must read 0 after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_skid  <= '0;
      r_level <= 2'd0;
    end else if (i_clear) begin
      r_level <= 2'd0;
    end else begin
      case (r_level)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_data;
            r_level <= 2'd1;
          end
        end
        2'd1: begin
          // Push with pop replaces the head directly; the skid stays empty.
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_skid  <= i_data;
            r_level <= 2'd2;
          end else if (i_pop) begin
            r_level <= 2'd0;
          end
        end
        default: begin
          if (i_pop) begin
            r_head <= r_skid;
            if (i_push) begin
              r_skid <= i_data;
            end else begin
              r_level <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  // A push into a full buffer with no pop is an over-read; the word is lost.
  assign o_drop  = i_push & ~i_pop & (r_level == 2'd2);
  assign o_head  = r_head;
  assign o_level = r_level;

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the TDP18K FIFO read port (pull, 1-cycle latency) into a VALID/READY
// stream without ever reading the FIFO past its last word.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  FLUSH_i,
  input  logic                  EMPTY_i,
  input  logic                  EPO_i,
  input  logic                  UNDERRUN_i,
  output logic                  REN_o,
  input  logic [DATA_WIDTH-1:0] RDATA_i,
  output logic                  VALID_o,
  input  logic                  READY_i,
  output logic [DATA_WIDTH-1:0] DATA_o,
  output level_t                LEVEL_o,
  output logic                  ERR_o
);

  if (SKID_DEPTH != 2) begin : g_bad_depth
    $error("fifo_rd_stream: SKID_DEPTH must be 2");
  end

  logic   r_ren_q;
  logic   r_flush_q;
  logic   r_err;
  level_t w_level;
  logic   w_pop;
  logic   w_push;
  logic   w_drop;
  logic [2:0] w_occupancy;

  assign VALID_o = (w_level != 2'd0);
  assign w_pop   = VALID_o & READY_i;

  // Words held after this edge plus the one already in flight; READY_i feeds
  // this combinationally so a full buffer can still issue when it is draining.
  assign w_occupancy = {1'b0, w_level} + {2'b00, r_ren_q} - {2'b00, w_pop};

  // Flags lag one read: with EPO_i set and a read in flight the FIFO is empty.
  assign REN_o = ~RST_i & ~FLUSH_i & ~r_flush_q & ~EMPTY_i
               & ~(EPO_i & r_ren_q) & (w_occupancy < 3'(SKID_DEPTH));

  assign w_push = r_ren_q & ~FLUSH_i & ~r_flush_q;

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_ren_q   <= 1'b0;
      r_flush_q <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ren_q   <= REN_o & ~FLUSH_i;
      r_flush_q <= FLUSH_i;
      r_err     <= r_err | UNDERRUN_i | w_drop;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk   (CLK_i),
    .i_rst   (RST_i),
    .i_clear (FLUSH_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (RDATA_i),
    .o_head  (DATA_o),
    .o_level (w_level),
    .o_drop  (w_drop)
  );

  assign LEVEL_o = w_level;
  assign ERR_o   = r_err;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream driven by a FIFO model with lagging flags.
module tb_fifo_rd_stream;

  localparam int DW = 18;

  logic          CLK_i = 1'b0;
  logic          RST_i = 1'b1;
  logic          FLUSH_i = 1'b0;
  logic          EMPTY_i;
  logic          EPO_i;
  logic          UNDERRUN_i = 1'b0;
  logic          REN_o;
  logic [DW-1:0] RDATA_i = '0;
  logic          VALID_o;
  logic          READY_i = 1'b0;
  logic [DW-1:0] DATA_o;
  logic [1:0]    LEVEL_o;
  logic          ERR_o;

  always #5 CLK_i = ~CLK_i;

  fifo_rd_stream #(
    .DATA_WIDTH (DW)
  ) dut (
    .CLK_i      (CLK_i),
    .RST_i      (RST_i),
    .FLUSH_i    (FLUSH_i),
    .EMPTY_i    (EMPTY_i),
    .EPO_i      (EPO_i),
    .UNDERRUN_i (UNDERRUN_i),
    .REN_o      (REN_o),
    .RDATA_i    (RDATA_i),
    .VALID_o    (VALID_o),
    .READY_i    (READY_i),
    .DATA_o     (DATA_o),
    .LEVEL_o    (LEVEL_o),
    .ERR_o      (ERR_o)
  );

  // FIFO model: flags in a cycle reflect the count one cycle earlier.
  logic [DW-1:0] mem [0:15];
  int  cnt = 0, lag_cnt = 0, rd_ptr = 0, overreads = 0;
  logic load_req = 1'b0;
  int  load_n = 0;

  assign EMPTY_i = (lag_cnt == 0);
  assign EPO_i   = (lag_cnt == 1);

  always @(posedge CLK_i) begin
    if (load_req) begin
      cnt     <= load_n;
      lag_cnt <= load_n;
      rd_ptr  <= 0;
    end else begin
      lag_cnt <= cnt;
      if (REN_o) begin
        if (cnt == 0) begin
          overreads <= overreads + 1;
        end else begin
          RDATA_i <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + 1;
          cnt     <= cnt - 1;
        end
      end
    end
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic          s_ren, s_valid, s_err;
  logic [DW-1:0] s_data;
  logic [1:0]    s_level;
  logic [DW-1:0] pop_q [$];
  int            pop_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, sample outputs at the falling edge, log pops.
  task automatic cycle(input logic ready, input logic flush, input logic underrun);
    READY_i    = ready;
    FLUSH_i    = flush;
    UNDERRUN_i = underrun;
    @(negedge CLK_i);
    s_ren   = REN_o;
    s_valid = VALID_o;
    s_data  = DATA_o;
    s_level = LEVEL_o;
    s_err   = ERR_o;
    if (VALID_o && READY_i) begin
      pop_q.push_back(DATA_o);
      pop_cyc.push_back(cyc);
    end
    @(posedge CLK_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);
    RST_i = 1'b1; load_req = 1'b1; load_n = n;
    READY_i = 1'b0; FLUSH_i = 1'b0; UNDERRUN_i = 1'b0;
    @(posedge CLK_i);
    #1;
    @(negedge CLK_i);
    check("rst_ren",   32'(REN_o),   0);
    check("rst_valid", 32'(VALID_o), 0);
    check("rst_data",  32'(DATA_o),  0);
    check("rst_level", 32'(LEVEL_o), 0);
    check("rst_err",   32'(ERR_o),   0);
    @(posedge CLK_i);
    #1;
    RST_i = 1'b0; load_req = 1'b0;
    cyc = 0;
    pop_q.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ren_cnt, ren_first, ren_last;

    // Streaming at full rate: 8 back-to-back reads, words 1..8 from cycle 2.
    do_reset(8);
    ren_cnt = 0; ren_first = -1; ren_last = -1;
    for (int c = 0; c < 14; c++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (s_ren) begin
        ren_cnt++;
        if (ren_first < 0) ren_first = c;
        ren_last = c;
      end
    end
    check("t1_ren_cnt",   32'(ren_cnt),   8);
    check("t1_ren_first", 32'(ren_first), 0);
    check("t1_ren_last",  32'(ren_last),  7);
    check("t1_pop_cnt",   32'(pop_q.size()), 8);
    for (int i = 0; i < pop_q.size() && i < 8; i++) begin
      check($sformatf("t1_word%0d", i), 32'(pop_q[i]), 32'(i + 1));
      check($sformatf("t1_cyc%0d", i),  32'(pop_cyc[i]), 32'(i + 2));
    end
    check("t1_err", 32'(s_err), 0);

    // Backpressure: exactly two reads, level 2, head held, then full drain.
    do_reset(8);
    ren_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (s_ren) ren_cnt++;
    end
    check("t2_ren_held", 32'(ren_cnt), 2);
    check("t2_level",    32'(s_level), 2);
    check("t2_valid",    32'(s_valid), 1);
    check("t2_head",     32'(s_data),  1);
    for (int c = 0; c < 14; c++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (s_ren) ren_cnt++;
    end
    check("t2_ren_total", 32'(ren_cnt), 8);
    check("t2_pop_cnt",   32'(pop_q.size()), 8);
    for (int i = 0; i < pop_q.size() && i < 8; i++)
      check($sformatf("t2_word%0d", i), 32'(pop_q[i]), 32'(i + 1));
    check("t2_level_end", 32'(s_level), 0);

    // Single word with lagging flags: one read only.
    do_reset(1);
    mem[0] = 18'h0002A;
    ren_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (s_ren) ren_cnt++;
    end
    check("t3_ren_cnt", 32'(ren_cnt), 1);
    check("t3_pop_cnt", 32'(pop_q.size()), 1);
    if (pop_q.size() > 0) check("t3_word", 32'(pop_q[0]), 32'h2A);
    check("t3_err", 32'(s_err), 0);

    // Flush the cycle after a read issued at level 2.
    do_reset(8);
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t4_ren_pre",   32'(s_ren),   1);
    check("t4_level_pre", 32'(s_level), 2);
    cycle(1'b0, 1'b1, 1'b0);
    check("t4_ren_flush", 32'(s_ren), 0);
    pop_q.delete();
    cycle(1'b1, 1'b0, 1'b0);
    check("t4_ren_after", 32'(s_ren),   0);
    check("t4_level_0",   32'(s_level), 0);
    check("t4_valid_0",   32'(s_valid), 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t4_ren_resume", 32'(s_ren), 1);
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 1'b0);
    check("t4_pop_cnt", 32'(pop_q.size() >= 2), 1);
    if (pop_q.size() >= 2) begin
      check("t4_word0", 32'(pop_q[0]), 4);
      check("t4_word1", 32'(pop_q[1]), 5);
    end
    check("t4_err", 32'(s_err), 0);

    // Underrun makes ERR sticky; a mid-stream reset clears everything.
    do_reset(8);
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("t5_err_same", 32'(s_err), 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t5_err_set", 32'(s_err), 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t5_err_hold", 32'(s_err), 1);
    check("t5_valid_mid", 32'(s_valid), 1);
    RST_i = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    check("t5_ren_rst", 32'(s_ren), 0);
    check("t5_err_rst", 32'(s_err), 1);
    RST_i = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    check("t5_valid_post", 32'(s_valid), 0);
    check("t5_level_post", 32'(s_level), 0);
    check("t5_data_post",  32'(s_data),  0);
    check("t5_err_post",   32'(s_err),   0);

    check("overreads", 32'(overreads), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
